aibcr3_rxalign: RTL and testbench



---
 rtl/aibcr3_rxalign_pkg.sv | 32 +++
 rtl/aibcr3_rxalign_deser.sv | 80 ++++++++
 rtl/aibcr3_rxalign.sv | 153 +++++++++++++++
 tb/tb_aibcr3_rxalign.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aibcr3_rxalign_pkg.sv
// ============================================================================
// Module      : aibcr3_rxalign_pkg
// Description : Shared types and constants for the AIB receive word aligner.
//               The AIBCR3_RXALIGN_BITSLIP_EN macro selects 1-bit slip granularity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aibcr3_rxalign_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } state_e;

  localparam logic [7:0] DEFAULT_MARKER = 8'hB4;
  localparam int         SLIP_CNT_W     = 8;

  // Number of slips that walks the boundary through every candidate position.
  function automatic int fail_slips(input int word_w);
`ifdef AIBCR3_RXALIGN_BITSLIP_EN
    return word_w;
`else
    return word_w / 2;
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/aibcr3_rxalign_deser.sv
// ============================================================================
// Module      : aibcr3_rxalign_deser
// Description : DDR pair deserialiser with phase counter and slip control.
//               AIBCR3_RXALIGN_BITSLIP_EN adds the odd-bit delay path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aibcr3_rxalign_deser #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_dat0,
  input  logic              rx_dat1,
  input  logic              slip,
  output logic [WORD_W-1:0] word,
  output logic              boundary
);

  localparam int              PH_W    = $clog2(WORD_W / 2);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(WORD_W / 2 - 1);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [1:0]        pair;
  logic              hold;

`ifdef AIBCR3_RXALIGN_BITSLIP_EN
  logic odd_q, odd_d;
  logic prev_dat1_q;

  // The toggled odd flag already selects the pair in the slip cycle itself,
  // so the following boundary window contains no duplicated bit.
  always_comb begin
    odd_d = odd_q ^ slip;
    hold  = slip & odd_q;
    pair  = odd_d ? {prev_dat1_q, rx_dat0} : {rx_dat0, rx_dat1};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      odd_q       <= 1'b0;
      prev_dat1_q <= 1'b0;
    end else begin
      odd_q       <= odd_d;
      prev_dat1_q <= rx_dat1;
    end
  end
`else
  always_comb begin
    hold = slip;
    pair = {rx_dat0, rx_dat1};
  end
`endif

  always_comb begin
    sr_d = {sr_q[WORD_W-3:0], pair};
    ph_d = ph_q;
    if (!hold) begin
      ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
    end
  end

  assign word     = sr_d;
  assign boundary = (ph_q == PH_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q <= '0;
      ph_q <= '0;
    end else begin
      sr_q <= sr_d;
      ph_q <= ph_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/aibcr3_rxalign.sv
// ============================================================================
// Module      : aibcr3_rxalign
// Description : AIB receive word aligner: marker training FSM and outputs.
//               AIBCR3_RXALIGN_BITSLIP_EN enables 1-bit slip granularity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aibcr3_rxalign
  import aibcr3_rxalign_pkg::*;
#(
  parameter int              WORD_W   = 8,
  parameter logic [WORD_W-1:0] MARKER = WORD_W'(DEFAULT_MARKER),
  parameter int              LOCK_CNT = 4
) (
  input  logic                  iclkin_dist,
  input  logic                  irstb,
  input  logic                  rx_dat0,
  input  logic                  rx_dat1,
  input  logic                  align_en,
  output logic [WORD_W-1:0]     rx_word,
  output logic                  rx_word_vld,
  output logic                  rx_lock,
  output logic                  align_fail,
  output logic [SLIP_CNT_W-1:0] slip_cnt
);

  localparam int               MCNT_W      = $clog2(LOCK_CNT + 1);
  localparam logic [MCNT_W-1:0] MCNT_LOCK  = MCNT_W'(LOCK_CNT);
  localparam int               FAIL_SLIPS  = fail_slips(WORD_W);

  logic [WORD_W-1:0] word;
  logic              boundary;
  logic              match;

  state_e                  state_q, state_d;
  logic [MCNT_W-1:0]       mcnt_q, mcnt_d;
  logic                    slip_q, slip_d;
  logic [SLIP_CNT_W-1:0]   slip_cnt_q, slip_cnt_d;
  logic                    align_fail_q, align_fail_d;
  logic [WORD_W-1:0]       rx_word_q, rx_word_d;
  logic                    rx_word_vld_q, rx_word_vld_d;
  logic                    rx_lock_q, rx_lock_d;

  aibcr3_rxalign_deser #(
    .WORD_W (WORD_W)
  ) u_deser (
    .clk      (iclkin_dist),
    .rst_n    (irstb),
    .rx_dat0  (rx_dat0),
    .rx_dat1  (rx_dat1),
    .slip     (slip_q),
    .word     (word),
    .boundary (boundary)
  );

  assign match = (word == MARKER);

  always_comb begin
    state_d       = state_q;
    mcnt_d        = mcnt_q;
    slip_d        = 1'b0;
    slip_cnt_d    = slip_cnt_q;
    align_fail_d  = align_fail_q;
    rx_word_d     = rx_word_q;
    rx_word_vld_d = 1'b0;

    if (!align_en) begin
      state_d      = IDLE;
      mcnt_d       = '0;
      align_fail_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = SEARCH;
          mcnt_d       = '0;
          slip_cnt_d   = '0;
          align_fail_d = 1'b0;
        end
        SEARCH: begin
          if (boundary) begin
            if (match) begin
              mcnt_d  = MCNT_W'(1);
              state_d = (LOCK_CNT == 1) ? LOCKED : VERIFY;
            end else begin
              // The slip itself lands in the next cycle via slip_q.
              slip_d = 1'b1;
              if (slip_cnt_q != '1) begin
                slip_cnt_d = slip_cnt_q + 1'b1;
              end
              if ((int'(slip_cnt_q) + 1) >= FAIL_SLIPS) begin
                align_fail_d = 1'b1;
              end
            end
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (match) begin
              mcnt_d = mcnt_q + 1'b1;
              if ((mcnt_q + 1'b1) == MCNT_LOCK) begin
                state_d = LOCKED;
              end
            end else begin
              state_d = SEARCH;
              mcnt_d  = '0;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            rx_word_d     = word;
            rx_word_vld_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    rx_lock_d = (state_d == LOCKED);
  end

  always_ff @(posedge iclkin_dist) begin
    if (!irstb) begin
      state_q       <= IDLE;
      mcnt_q        <= '0;
      slip_q        <= 1'b0;
      slip_cnt_q    <= '0;
      align_fail_q  <= 1'b0;
      rx_word_q     <= '0;
      rx_word_vld_q <= 1'b0;
      rx_lock_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mcnt_q        <= mcnt_d;
      slip_q        <= slip_d;
      slip_cnt_q    <= slip_cnt_d;
      align_fail_q  <= align_fail_d;
      rx_word_q     <= rx_word_d;
      rx_word_vld_q <= rx_word_vld_d;
      rx_lock_q     <= rx_lock_d;
    end
  end

  assign rx_word     = rx_word_q;
  assign rx_word_vld = rx_word_vld_q;
  assign rx_lock     = rx_lock_q;
  assign align_fail  = align_fail_q;
  assign slip_cnt    = slip_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_aibcr3_rxalign.sv
// ============================================================================
// Module      : tb_aibcr3_rxalign
// Description : Directed self-checking bench for aibcr3_rxalign (WORD_W=8).
//               Honours AIBCR3_RXALIGN_BITSLIP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aibcr3_rxalign;

  localparam int         W  = 8;
  localparam logic [7:0] MK = 8'hB4;
`ifdef AIBCR3_RXALIGN_BITSLIP_EN
  localparam int FAIL_N    = 8;
  localparam int FAIL_EDGE = 35;
`else
  localparam int FAIL_N    = 4;
  localparam int FAIL_EDGE = 19;
`endif

  logic         clk = 1'b0;
  logic         irstb, rx_dat0, rx_dat1, align_en;
  logic [W-1:0] rx_word;
  logic         rx_word_vld, rx_lock, align_fail;
  logic [7:0]   slip_cnt;

  always #5 clk = ~clk;

  aibcr3_rxalign #(
    .WORD_W   (W),
    .MARKER   (MK),
    .LOCK_CNT (4)
  ) dut (
    .iclkin_dist (clk),
    .irstb       (irstb),
    .rx_dat0     (rx_dat0),
    .rx_dat1     (rx_dat1),
    .align_en    (align_en),
    .rx_word     (rx_word),
    .rx_word_vld (rx_word_vld),
    .rx_lock     (rx_lock),
    .align_fail  (align_fail),
    .slip_cnt    (slip_cnt)
  );

  int           n_chk = 0;
  int           n_bad = 0;
  int           cyc   = 0;
  int           n_vld = 0;
  bit           bitq[$];
  logic [W-1:0] capq[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) bitq.push_back(w[i]);
  endtask

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) bitq.push_back(1'b0);
  endtask

  // One clock: earliest queued bit goes on rx_dat0; outputs sampled 1 unit after the edge.
  task automatic step();
    bit b0;
    bit b1;
    b0 = 1'b0;
    b1 = 1'b0;
    if (bitq.size() > 0) b0 = bitq.pop_front();
    if (bitq.size() > 0) b1 = bitq.pop_front();
    rx_dat0 = b0;
    rx_dat1 = b1;
    @(posedge clk);
    #1;
    cyc++;
    if (rx_word_vld) begin
      n_vld++;
      capq.push_back(rx_word);
    end
  endtask

  task automatic step_to(input int e);
    while (cyc < e) step();
  endtask

  task automatic do_reset();
    irstb    = 1'b0;
    align_en = 1'b0;
    bitq.delete();
    capq.delete();
    repeat (3) begin
      rx_dat0 = 1'($urandom_range(0, 1));
      rx_dat1 = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    check_val("rst_word", 32'(rx_word), 0);
    check_val("rst_vld", 32'(rx_word_vld), 0);
    check_val("rst_lock", 32'(rx_lock), 0);
    check_val("rst_fail", 32'(align_fail), 0);
    check_val("rst_slip", 32'(slip_cnt), 0);
    irstb = 1'b1;
    cyc   = 0;
    n_vld = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    irstb    = 1'b0;
    align_en = 1'b0;
    rx_dat0  = 1'b0;
    rx_dat1  = 1'b0;

    // align_en low: markers stream but nothing is delivered
    do_reset();
    repeat (4) push_word(MK);
    step_to(16);
    check_val("idle_vld", 32'(n_vld), 0);
    check_val("idle_lock", 32'(rx_lock), 0);

    // Marker already aligned: lock at edge 16, payload every 4 cycles
    do_reset();
    align_en = 1'b1;
    repeat (4) push_word(MK);
    repeat (3) push_word(8'h3C);
    step_to(15);
    check_val("al_slip", 32'(slip_cnt), 0);
    check_val("al_lock15", 32'(rx_lock), 0);
    step_to(16);
    check_val("al_lock16", 32'(rx_lock), 1);
    step_to(19);
    check_val("al_novld", 32'(n_vld), 0);
    step_to(20);
    check_val("al_vld20", 32'(rx_word_vld), 1);
    check_val("al_word20", 32'(rx_word), 32'h3C);
    step_to(21);
    check_val("al_vld21", 32'(rx_word_vld), 0);
    step_to(31);
    align_en = 1'b0;
    step();
    check_val("al_drop_lock", 32'(rx_lock), 0);
    check_val("al_drop_vld", 32'(rx_word_vld), 0);
    check_val("al_nvld", 32'(n_vld), 3);
    check_val("al_fail", 32'(align_fail), 0);

    // Two markers, a corrupt word, then markers: back to SEARCH with no slip
    do_reset();
    align_en = 1'b1;
    push_word(MK);
    push_word(MK);
    push_word(8'hFF);
    repeat (4) push_word(MK);
    push_word(8'h5A);
    push_word(8'hC3);
    step_to(12);
    check_val("vf_slip12", 32'(slip_cnt), 0);
    check_val("vf_lock12", 32'(rx_lock), 0);
    step_to(27);
    check_val("vf_lock27", 32'(rx_lock), 0);
    step_to(28);
    check_val("vf_lock28", 32'(rx_lock), 1);
    step_to(36);
    check_val("vf_nvld", 32'(n_vld), 2);
    check_val("vf_w0", 32'(capq[0]), 32'h5A);
    check_val("vf_w1", 32'(capq[1]), 32'hC3);
    check_val("vf_slip", 32'(slip_cnt), 0);

`ifndef AIBCR3_RXALIGN_BITSLIP_EN
    // Marker 4 bits late: slips at edges 4 and 9, match at 14, lock at 26
    do_reset();
    align_en = 1'b1;
    push_zeros(4);
    repeat (6) push_word(MK);
    push_word(8'h3C);
    push_word(8'hA5);
    push_word(8'h96);
    step_to(4);
    check_val("of_slip4", 32'(slip_cnt), 1);
    step_to(8);
    check_val("of_slip8", 32'(slip_cnt), 1);
    step_to(9);
    check_val("of_slip9", 32'(slip_cnt), 2);
    step_to(25);
    check_val("of_lock25", 32'(rx_lock), 0);
    step_to(26);
    check_val("of_lock26", 32'(rx_lock), 1);
    step_to(38);
    check_val("of_nvld", 32'(n_vld), 3);
    check_val("of_w0", 32'(capq[0]), 32'h3C);
    check_val("of_w1", 32'(capq[1]), 32'hA5);
    check_val("of_w2", 32'(capq[2]), 32'h96);
    check_val("of_slip", 32'(slip_cnt), 2);
`else
    // Marker 3 bits late: boundary ends fall at stream bits 7,14,25,32,43,50,
    // so the fifth slip reaches the marker (edge 26) and lock follows at 38.
    do_reset();
    align_en = 1'b1;
    push_zeros(3);
    repeat (9) push_word(MK);
    push_word(8'h3C);
    push_word(8'hA5);
    push_word(8'h96);
    step_to(26);
    check_val("bs_slip26", 32'(slip_cnt), 5);
    check_val("bs_lock26", 32'(rx_lock), 0);
    step_to(37);
    check_val("bs_lock37", 32'(rx_lock), 0);
    step_to(38);
    check_val("bs_lock38", 32'(rx_lock), 1);
    step_to(50);
    check_val("bs_nvld", 32'(n_vld), 3);
    check_val("bs_w0", 32'(capq[0]), 32'h3C);
    check_val("bs_w1", 32'(capq[1]), 32'hA5);
    check_val("bs_w2", 32'(capq[2]), 32'h96);
    step_to(53);
    align_en = 1'b0;
    step();
    check_val("bs_drop_lock", 32'(rx_lock), 0);
    check_val("bs_drop_vld", 32'(rx_word_vld), 0);
`endif

    // No marker at all: align_fail on the FAIL_N-th slip, sticky, cleared by align_en low
    do_reset();
    align_en = 1'b1;
    while (int'(slip_cnt) < FAIL_N - 1 && cyc < 300) step();
    check_val("nm_fail_early", 32'(align_fail), 0);
    while (int'(slip_cnt) < FAIL_N && cyc < 300) step();
    check_val("nm_fail_edge", 32'(cyc), 32'(FAIL_EDGE));
    check_val("nm_fail_set", 32'(align_fail), 1);
    repeat (20) step();
    check_val("nm_sticky", 32'(align_fail), 1);
    check_val("nm_counting", 32'(int'(slip_cnt) > FAIL_N), 1);
    repeat (1500) step();
    check_val("nm_sat", 32'(slip_cnt), 255);
    check_val("nm_nolock", 32'(rx_lock), 0);
    align_en = 1'b0;
    step();
    check_val("nm_clr_fail", 32'(align_fail), 0);
    align_en = 1'b1;
    step();
    check_val("nm_clr_slip", 32'(slip_cnt), 0);
    check_val("nm_clr_fail2", 32'(align_fail), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
